// File: rtl/serial_byte_queue_top.sv
// Serial byte FIFO: a bit-serial writer shifts bytes in MSB-first, one bit per
// write_in rising edge. Each completed byte goes into a circular queue. A
// dequeue_in pulse pops the oldest byte and shifts it out on data_out MSB-first.
//
// Ports:
//   clock1M    - system clock, all logic on its rising edge
//   reset      - synchronous, active-high reset
//   data_in    - serial data bit, sampled on a write_in rising edge
//   write_in   - bit strobe (level); only its 0->1 transition matters
//   dequeue_in - pop request, sampled every clock
//   data_out   - serial output of the dequeued byte, 0 when idle
//   status_out - 1 when the queue holds DEPTH bytes
module serial_byte_queue_top #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8   // power of two, >= 2
) (
  input  logic clock1M,
  input  logic reset,
  input  logic data_in,
  input  logic write_in,
  input  logic dequeue_in,
  output logic data_out,
  output logic status_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(WIDTH);

  logic             r_write_q;
  logic [BW-1:0]    r_bit_cnt;
  // Only WIDTH-1 bits are kept: the oldest bit is flushed by the completing shift.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_ser_sh;
  logic [BW-1:0]    r_ser_left;
  logic             r_ser_busy;
  logic             r_data_out;
  logic             r_full;

  logic             w_write_evt;
  logic             w_byte_done;
  logic [WIDTH-1:0] w_byte;
  logic             w_ser_idle;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_count_nxt;

  assign w_write_evt = write_in & ~r_write_q;
  assign w_byte_done = w_write_evt && (r_bit_cnt == BW'(WIDTH - 1));
  assign w_byte      = {r_shift, data_in};

  // The bit0 cycle counts as idle so a held dequeue_in yields contiguous bytes.
  assign w_ser_idle  = !r_ser_busy || (r_ser_left == '0);
  assign w_pop       = dequeue_in && (r_count != '0) && w_ser_idle;
  // A pop in the same edge frees a slot, so a push into a full queue still lands.
  assign w_push      = w_byte_done && ((r_count != CW'(DEPTH)) || w_pop);

  // Occupancy next value
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = CW'(r_count + 1'b1);
      2'b01:   w_count_nxt = CW'(r_count - 1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Write-side: edge detect and deserializer
  always_ff @(posedge clock1M) begin
    if (reset) begin
      r_write_q <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_write_q <= write_in;
      if (w_write_evt) begin
        r_shift   <= w_byte[WIDTH-2:0];
        r_bit_cnt <= w_byte_done ? '0 : BW'(r_bit_cnt + 1'b1);
      end
    end
  end

  // Queue storage; contents are meaningless while count says empty
  always_ff @(posedge clock1M) begin
    if (w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  // Queue pointers, occupancy and full flag
  always_ff @(posedge clock1M) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Output serializer: bit7 appears the cycle after the pop edge
  always_ff @(posedge clock1M) begin
    if (reset) begin
      r_ser_sh   <= '0;
      r_ser_left <= '0;
      r_ser_busy <= 1'b0;
      r_data_out <= 1'b0;
    end else if (w_pop) begin
      r_ser_sh   <= {r_mem[r_rd_ptr][WIDTH-2:0], 1'b0};
      r_data_out <= r_mem[r_rd_ptr][WIDTH-1];
      r_ser_left <= BW'(WIDTH - 1);
      r_ser_busy <= 1'b1;
    end else if (r_ser_busy && (r_ser_left != '0)) begin
      r_data_out <= r_ser_sh[WIDTH-1];
      r_ser_sh   <= {r_ser_sh[WIDTH-2:0], 1'b0};
      r_ser_left <= BW'(r_ser_left - 1'b1);
    end else begin
      r_ser_busy <= 1'b0;
      r_data_out <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign status_out = r_full;

endmodule

// File: tb/tb_serial_byte_queue_top.sv
// Bench for serial_byte_queue_top: scenario tasks drive the serial writer and
// dequeue port, and compare data_out/status_out against a byte-queue model.
module tb_serial_byte_queue_top;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic clock1M = 1'b0;
  logic reset;
  logic data_in;
  logic write_in;
  logic dequeue_in;
  logic data_out;
  logic status_out;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_q[$];

  serial_byte_queue_top #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock1M   (clock1M),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .dequeue_in(dequeue_in),
    .data_out  (data_out),
    .status_out(status_out)
  );

  always #5 clock1M = ~clock1M;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock1M);
    #1;
  endtask

  task automatic write_bit(input logic b, input int hi, input int lo);
    data_in  = b;
    write_in = 1'b1;
    repeat (hi) tick();
    write_in = 1'b0;
    repeat (lo) tick();
  endtask

  // Send a byte MSB-first and record it in the model (dropped when full)
  task automatic write_byte(input logic [7:0] v, input int hi, input int lo);
    for (int i = 7; i >= 0; i--) write_bit(v[i], hi, lo);
    if (model_q.size() < DEPTH) model_q.push_back(v);
  endtask

  // Assumes the pop edge has just passed, so data_out currently shows bit7
  task automatic collect_byte(output logic [7:0] b, output logic tail);
    for (int i = 7; i >= 0; i--) begin
      b[i] = data_out;
      tick();
    end
    tail = data_out;
  endtask

  task automatic read_byte(output logic [7:0] b, output logic st, output logic tail);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    st = status_out;
    collect_byte(b, tail);
  endtask

  // Pulse dequeue and count cycles in which data_out is nonzero
  task automatic pulse_idle(output int ones);
    ones = 0;
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    if (data_out !== 1'b0) ones++;
    repeat (9) begin
      tick();
      if (data_out !== 1'b0) ones++;
    end
  endtask

  task automatic test_reset();
    int ones;
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; dequeue_in = 1'b0;
    repeat (10) begin
      tick();
      total++;
      if (data_out !== 1'b0 || status_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: data_out=%b status_out=%b expected 0 0", data_out, status_out);
      end
    end
    reset = 1'b0;
    model_q.delete();
    pulse_idle(ones);
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL reset_pop_empty: data_out high %0d cycles expected 0", ones);
    end
  endtask

  task automatic test_byte_order();
    logic [7:0] b; logic st, tail; int ones;
    write_byte(8'hA5, 10, 10);
    write_byte(8'h3C, 10, 10);
    repeat (1000) tick();
    read_byte(b, st, tail);
    total++;
    if (b !== 8'hA5 || tail !== 1'b0) begin
      bad++;
      $display("FAIL order_first: got %h tail %b expected a5 tail 0", b, tail);
    end
    void'(model_q.pop_front());
    repeat (100) tick();
    read_byte(b, st, tail);
    total++;
    if (b !== 8'h3C || tail !== 1'b0) begin
      bad++;
      $display("FAIL order_second: got %h tail %b expected 3c tail 0", b, tail);
    end
    void'(model_q.pop_front());
    pulse_idle(ones);
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL order_third_empty: data_out high %0d cycles expected 0", ones);
    end
  endtask

  task automatic test_edge_only();
    logic [7:0] b; logic st, tail; int ones;
    data_in = 1'b1;
    write_in = 1'b1;
    repeat (50) tick();
    write_in = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 7; i++) write_bit(1'b0, 2, 2);
    model_q.push_back(8'h80);
    read_byte(b, st, tail);
    total++;
    if (b !== 8'h80) begin
      bad++;
      $display("FAIL edge_only_byte: got %h expected 80", b);
    end
    void'(model_q.pop_front());
    pulse_idle(ones);
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL edge_only_single: data_out high %0d cycles expected 0", ones);
    end
  endtask

  task automatic test_full_drop();
    logic [7:0] b, exp; logic st, tail;
    for (int i = 1; i <= 8; i++) write_byte(8'(i), 1, 2);
    total++;
    if (status_out !== 1'b1) begin
      bad++;
      $display("FAIL full_after_8: status_out=%b expected 1", status_out);
    end
    write_byte(8'hFF, 1, 2);
    total++;
    if (status_out !== 1'b1 || model_q.size() != DEPTH) begin
      bad++;
      $display("FAIL full_drop_status: status_out=%b expected 1", status_out);
    end
    read_byte(b, st, tail);
    exp = model_q.pop_front();
    total++;
    if (b !== exp || b !== 8'h01 || st !== 1'b0) begin
      bad++;
      $display("FAIL full_first_pop: got %h status %b expected 01 status 0", b, st);
    end
    while (model_q.size() > 0) begin
      read_byte(b, st, tail);
      exp = model_q.pop_front();
      total++;
      if (b !== exp || tail !== 1'b0) begin
        bad++;
        $display("FAIL full_drain: got %h tail %b expected %h tail 0", b, tail, exp);
      end
    end
    // Refill across the pointer wrap
    for (int i = 0; i < 5; i++) write_byte(8'($urandom), 1, 1);
    while (model_q.size() > 0) begin
      read_byte(b, st, tail);
      exp = model_q.pop_front();
      total++;
      if (b !== exp) begin
        bad++;
        $display("FAIL wrap_refill: got %h expected %h", b, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b; logic st, tail; int ones;
    write_byte(8'hFF, 2, 2);
    write_byte(8'h77, 2, 2);
    write_bit(1'b1, 1, 1); write_bit(1'b0, 1, 1);
    write_bit(1'b1, 1, 1); write_bit(1'b1, 1, 1);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q.delete();
    total++;
    if (data_out !== 1'b0 || status_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: data_out=%b status_out=%b expected 0 0", data_out, status_out);
    end
    pulse_idle(ones);
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL reset_mid_empty: data_out high %0d cycles expected 0", ones);
    end
    write_byte(8'h5A, 3, 3);
    read_byte(b, st, tail);
    void'(model_q.pop_front());
    total++;
    if (b !== 8'h5A || tail !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_5a: got %h tail %b expected 5a tail 0", b, tail);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b, exp, nb; logic st, tail;
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom), 1, 1);
    nb = 8'($urandom);
    for (int i = 7; i >= 1; i--) write_bit(nb[i], 1, 1);
    data_in    = nb[0];
    write_in   = 1'b1;
    dequeue_in = 1'b1;
    tick();
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    st = status_out;
    total++;
    if (st !== 1'b1) begin
      bad++;
      $display("FAIL simul_status: status_out=%b expected 1", st);
    end
    collect_byte(b, tail);
    exp = model_q.pop_front();
    model_q.push_back(nb);
    total++;
    if (b !== exp) begin
      bad++;
      $display("FAIL simul_head: got %h expected %h", b, exp);
    end
    while (model_q.size() > 0) begin
      read_byte(b, st, tail);
      exp = model_q.pop_front();
      total++;
      if (b !== exp) begin
        bad++;
        $display("FAIL simul_order: got %h expected %h", b, exp);
      end
    end
    total++;
    if (status_out !== 1'b0) begin
      bad++;
      $display("FAIL simul_drained_status: status_out=%b expected 0", status_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [3];
    logic [7:0] got [3];
    logic tail;
    for (int j = 0; j < 3; j++) begin
      v[j] = 8'($urandom);
      write_byte(v[j], 1, 1);
    end
    dequeue_in = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      for (int i = 7; i >= 0; i--) begin
        got[j][i] = data_out;
        tick();
      end
    end
    dequeue_in = 1'b0;
    tail = data_out;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (got[j] !== v[j]) begin
        bad++;
        $display("FAIL b2b_byte%0d: got %h expected %h", j, got[j], v[j]);
      end
      void'(model_q.pop_front());
    end
    total++;
    if (tail !== 1'b0) begin
      bad++;
      $display("FAIL b2b_tail: data_out=%b expected 0", tail);
    end
  endtask

  task automatic test_random();
    logic [7:0] b, exp; logic st, tail; int ones;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) < 2) begin
        write_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
        total++;
        if (status_out !== (model_q.size() == DEPTH)) begin
          bad++;
          $display("FAIL rand_status: status_out=%b expected %b", status_out, model_q.size() == DEPTH);
        end
      end else if (model_q.size() == 0) begin
        pulse_idle(ones);
        total++;
        if (ones !== 0) begin
          bad++;
          $display("FAIL rand_empty_pop: data_out high %0d cycles expected 0", ones);
        end
      end else begin
        read_byte(b, st, tail);
        exp = model_q.pop_front();
        total++;
        if (b !== exp || st !== 1'b0 || tail !== 1'b0) begin
          bad++;
          $display("FAIL rand_pop: got %h st %b tail %b expected %h st 0 tail 0", b, st, tail, exp);
        end
      end
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_byte_order();
    test_edge_only();
    test_full_drop();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
